perceptron_btb_spec: RTL

Parametrised successor to the team's single-table perceptron BTB. It adds tag-checked BTB entries and separately sized BTB and perceptron tables, and keeps both a speculative and an architectural global history with mispredict recovery. Weights are saturating and are cleared by a post-reset init sweep. It sits between fetch (same-cycle prediction) and ROB commit (training and allocation).

---
 rtl/perceptron_btb_spec.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/perceptron_btb_spec.sv
// Perceptron branch predictor with a tag-checked BTB, speculative/architectural
// global history, saturating weights and a post-reset table init sweep.
module perceptron_btb_spec #(
  parameter int unsigned BTB_IDX_BITS  = 6,
  parameter int unsigned PERC_IDX_BITS = 6,
  parameter int unsigned GHR_LEN       = 12,
  parameter int unsigned WEIGHT_W      = 8,
  parameter int unsigned THETA         = 37
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_valid,
  input  logic [31:0]        fetch_pc,
  output logic               pred_hit,
  output logic               pred_taken,
  output logic [31:0]        pred_target,
  output logic [GHR_LEN-1:0] ghr_out,
  output logic               ready,
  input  logic               commit_valid,
  input  logic [31:0]        commit_pc,
  input  logic               commit_is_branch,
  input  logic               commit_is_jump,
  input  logic               commit_taken,
  input  logic [31:0]        commit_target,
  input  logic               commit_mispredict
);

  localparam int unsigned BTB_N      = 1 << BTB_IDX_BITS;
  localparam int unsigned PERC_N     = 1 << PERC_IDX_BITS;
  localparam int unsigned TAG_W      = 30 - BTB_IDX_BITS;
  localparam int unsigned SWEEP_BITS = (BTB_IDX_BITS > PERC_IDX_BITS) ? BTB_IDX_BITS : PERC_IDX_BITS;
  localparam int unsigned SUM_W      = WEIGHT_W + $clog2(GHR_LEN + 1) + 1;

  localparam logic [SWEEP_BITS-1:0] SWEEP_LAST = '1;
  localparam logic [WEIGHT_W-1:0]   W_MAX      = {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic [WEIGHT_W-1:0]   W_MIN      = {1'b1, {(WEIGHT_W-1){1'b0}}};

  typedef logic [GHR_LEN-1:0][WEIGHT_W-1:0] wvec_t;
  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [SWEEP_BITS-1:0]   sweep_q, sweep_d;
  logic [GHR_LEN-1:0]      spec_ghr_q, spec_ghr_d;
  logic [GHR_LEN-1:0]      arch_ghr_q, arch_ghr_d;
  logic [BTB_N-1:0]        btb_valid_q, btb_valid_d;

  logic [TAG_W-1:0]        btb_tag_q    [BTB_N];
  logic [31:0]             btb_target_q [BTB_N];
  logic                    btb_jump_q   [BTB_N];
  logic signed [WEIGHT_W-1:0] bias_q    [PERC_N];
  wvec_t                   w_q          [PERC_N];

  logic [BTB_IDX_BITS-1:0]  f_idx, c_idx;
  logic [TAG_W-1:0]         f_tag, c_tag;
  logic [PERC_IDX_BITS-1:0] f_pidx, c_pidx;
  logic signed [SUM_W-1:0]  f_y, c_y;
  logic [SUM_W-1:0]         c_abs;
  logic                     f_jump;
  logic                     c_en, c_jump, c_branch, c_write, c_train;
  logic [WEIGHT_W-1:0]      c_bias_new;
  wvec_t                    c_w_new;
  logic                     unused_pc_bits;

  assign unused_pc_bits = ^commit_pc[1:0];

  // Sign-extend one weight to the accumulator width.
  function automatic logic signed [SUM_W-1:0] sext(input logic [WEIGHT_W-1:0] v);
    return {{(SUM_W-WEIGHT_W){v[WEIGHT_W-1]}}, v};
  endfunction

  // Perceptron output: bias plus history-signed weights, wide enough never to overflow.
  function automatic logic signed [SUM_W-1:0] perc_sum(input logic [WEIGHT_W-1:0] b,
                                                       input wvec_t w,
                                                       input logic [GHR_LEN-1:0] h);
    logic signed [SUM_W-1:0] acc;
    acc = sext(b);
    for (int i = 0; i < int'(GHR_LEN); i++) begin
      acc = h[i] ? (acc + sext(w[i])) : (acc - sext(w[i]));
    end
    return acc;
  endfunction

  // Step a weight by +/-1, holding at the signed limits.
  function automatic logic [WEIGHT_W-1:0] sat_step(input logic [WEIGHT_W-1:0] v, input logic up);
    logic [WEIGHT_W-1:0] r;
    r = v;
    if (up && (v != W_MAX))       r = v + WEIGHT_W'(1);
    else if (!up && (v != W_MIN)) r = v - WEIGHT_W'(1);
    return r;
  endfunction

  assign ready   = (state_q == S_RUN);
  assign ghr_out = spec_ghr_q;

  // Same-cycle fetch prediction from the registered tables and the speculative history.
  always_comb begin
    f_idx       = fetch_pc[BTB_IDX_BITS+1:2];
    f_tag       = fetch_pc[31:BTB_IDX_BITS+2];
    f_pidx      = fetch_pc[PERC_IDX_BITS+1:2];
    f_y         = perc_sum(bias_q[f_pidx], w_q[f_pidx], spec_ghr_q);
    f_jump      = btb_jump_q[f_idx];
    pred_hit    = ready & fetch_valid & btb_valid_q[f_idx] & (btb_tag_q[f_idx] == f_tag);
    pred_taken  = 1'b0;
    pred_target = fetch_pc + 32'd4;
    if (pred_hit) begin
      pred_taken = f_jump | ~f_y[SUM_W-1];
      if (pred_taken) pred_target = btb_target_q[f_idx];
    end
  end

  // Commit-side decode, training decision and new weight values.
  always_comb begin
    c_idx      = commit_pc[BTB_IDX_BITS+1:2];
    c_tag      = commit_pc[31:BTB_IDX_BITS+2];
    c_pidx     = commit_pc[PERC_IDX_BITS+1:2];
    c_en       = commit_valid & (state_q == S_RUN);
    c_jump     = commit_is_jump;
    c_branch   = commit_is_branch & ~commit_is_jump;
    c_write    = c_en & (commit_is_branch | commit_is_jump);
    c_y        = perc_sum(bias_q[c_pidx], w_q[c_pidx], arch_ghr_q);
    c_abs      = c_y[SUM_W-1] ? SUM_W'(-c_y) : SUM_W'(c_y);
    c_train    = c_en & c_branch &
                 ((~c_y[SUM_W-1] != commit_taken) | (32'(c_abs) <= THETA));
    c_bias_new = sat_step(bias_q[c_pidx], commit_taken);
    c_w_new    = w_q[c_pidx];
    for (int i = 0; i < int'(GHR_LEN); i++) begin
      c_w_new[i] = sat_step(w_q[c_pidx][i], commit_taken == arch_ghr_q[i]);
    end
  end

  // Next-state: init sweep, valid bits and both history registers.
  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    btb_valid_d = btb_valid_q;
    spec_ghr_d  = spec_ghr_q;
    arch_ghr_d  = arch_ghr_q;
    case (state_q)
      S_INIT: begin
        btb_valid_d[sweep_q[BTB_IDX_BITS-1:0]] = 1'b0;
        sweep_d = sweep_q + SWEEP_BITS'(1);
        if (sweep_q == SWEEP_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (pred_hit & ~f_jump) spec_ghr_d = {spec_ghr_q[GHR_LEN-2:0], pred_taken};
        if (c_write) btb_valid_d[c_idx] = 1'b1;
        if (c_en & c_branch) arch_ghr_d = {arch_ghr_q[GHR_LEN-2:0], commit_taken};
        if (c_en & commit_mispredict & c_branch)
          spec_ghr_d = {arch_ghr_q[GHR_LEN-2:0], commit_taken};
        else if (c_en & commit_mispredict & c_jump)
          spec_ghr_d = arch_ghr_q;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_INIT;
      sweep_q     <= '0;
      btb_valid_q <= '0;
      spec_ghr_q  <= '0;
      arch_ghr_q  <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      btb_valid_q <= btb_valid_d;
      spec_ghr_q  <= spec_ghr_d;
      arch_ghr_q  <= arch_ghr_d;
    end
  end

  // Table storage: cleared by the sweep, written by commits.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      bias_q[sweep_q[PERC_IDX_BITS-1:0]] <= '0;
      w_q[sweep_q[PERC_IDX_BITS-1:0]]    <= '0;
    end else begin
      if (c_write) begin
        btb_tag_q[c_idx]    <= c_tag;
        btb_target_q[c_idx] <= commit_target;
        btb_jump_q[c_idx]   <= c_jump;
      end
      if (c_train) begin
        bias_q[c_pidx] <= c_bias_new;
        w_q[c_pidx]    <= c_w_new;
      end
    end
  end

endmodule
